id_stage_hazard: RTL and testbench

Parametrised instruction-decode stage for the pipelined ARMv8 core, with its own ID/EX pipeline register. It holds the register file, decodes the LEGv8 subset, and resolves B/BL/BR/CBZ/CBNZ in ID. It also contains a hazard unit that stalls IF/ID for load-use and in-ID branch-operand dependencies, and it counts stall cycles. It sits between the IF/ID register and the EX stage.

---
 rtl/id_stage_hazard_if.sv | 39 +++
 rtl/id_stage_hazard.sv | 242 ++++++++++++++++++++++++
 tb/tb_id_stage_hazard.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_hazard_if.sv
// ID/EX pipeline-register bundle carried from the decode stage to EX.
// Latency: none (wires only); the driving stage registers every field.
// Backpressure: none on this bundle; stalls are signalled beside it.
//
// Fields: ex_valid plus control bits, ALU op, register indices for EX
// forwarding, the two register operands, the immediate and the PC.
// master = decode stage (drives), slave = EX stage (consumes).
interface id_stage_hazard_if #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  ex_valid;
    logic                  ex_alu_src;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_mem_to_reg;
    logic                  ex_reg_write;
    logic                  ex_link;
    logic [1:0]            ex_alu_op;
    logic [REG_ADDR_W-1:0] ex_rn;
    logic [REG_ADDR_W-1:0] ex_rm;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]     ex_read_data1;
    logic [DATA_W-1:0]     ex_read_data2;
    logic [DATA_W-1:0]     ex_imm;
    logic [DATA_W-1:0]     ex_pc;

    modport master (
        output ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_reg_write, ex_link, ex_alu_op, ex_rn, ex_rm, ex_rd,
               ex_read_data1, ex_read_data2, ex_imm, ex_pc
    );

    modport slave (
        input  ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_reg_write, ex_link, ex_alu_op, ex_rn, ex_rm, ex_rd,
               ex_read_data1, ex_read_data2, ex_imm, ex_pc
    );
endinterface

// File: rtl/id_stage_hazard.sv
// LEGv8 decode stage: register file, decode, in-ID branch resolution, hazard unit, stall counter.
// Latency: 1 cycle into the ID/EX register; branch redirect and stall are combinational.
// Backpressure: stall holds PC and IF/ID while a dependency persists; ID/EX takes a bubble meanwhile.
//
// Ports: clock, reset (async, active low); IF/ID inputs if_valid/if_instr/if_pc;
// EX/MEM producer info mem_*; writeback wb_*; outputs stall, flush, branch_taken,
// branch_target, stall_count; ID/EX bundle on interface port ex (master).
// Build option ID_BYPASS_EN: write-through register file and no WB-stage hazard check.
// Without it a same-cycle read returns the old value and WB producers stall ID.
module id_stage_hazard #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [DATA_W-1:0]     if_pc,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  stall,
    output logic                  flush,
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     branch_target,
    output logic [CNT_W-1:0]      stall_count,
    id_stage_hazard_if.master     ex
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] XZR      = '1;
    localparam logic [REG_ADDR_W-1:0] LINK_REG = REG_ADDR_W'(30);

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;

    // Load-miss info from MEM is not needed here: ALU forwarding covers it.
    logic unused_mem_mem_read;
    assign unused_mem_mem_read = mem_mem_read;

    // A source of XZR is the constant zero and never depends on anything.
    function automatic logic src_hit(input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
        return (src != XZR) && (src == dst);
    endfunction

    // ---------------------------------------------------------------- decode
    logic [10:0]           opcode;
    logic                  is_ldur, is_stur, is_rtype, is_cbz, is_cbnz, is_cb;
    logic                  is_b, is_bl, is_br;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd_idx;
    logic [DATA_W-1:0]     imm;
    logic                  dec_valid, dec_alu_src, dec_mem_read, dec_mem_write;
    logic                  dec_mem_to_reg, dec_reg_write, dec_link;
    logic [1:0]            dec_alu_op;

    always_comb begin
        opcode   = if_instr[31:21];
        is_ldur  = (opcode == OP_LDUR);
        is_stur  = (opcode == OP_STUR);
        is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_ORR);
        is_cbz   = (if_instr[31:24] == 8'b10110100);
        is_cbnz  = (if_instr[31:24] == 8'b10110101);
        is_cb    = is_cbz || is_cbnz;
        is_b     = (if_instr[31:26] == 6'b000101);
        is_bl    = (if_instr[31:26] == 6'b100101);
        is_br    = (opcode == OP_BR);

        rs1    = REG_ADDR_W'(if_instr[9:5]);
        // STUR and CB read their Rt through port 2.
        rs2    = (is_stur || is_cb) ? REG_ADDR_W'(if_instr[4:0]) : REG_ADDR_W'(if_instr[20:16]);
        rd_idx = is_bl ? LINK_REG : REG_ADDR_W'(if_instr[4:0]);

        imm = '0;
        if (is_ldur || is_stur)
            imm = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
        else if (is_cb)
            imm = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
        else if (is_b || is_bl)
            imm = {{(DATA_W-26){if_instr[25]}}, if_instr[25:0]};

        dec_valid      = is_ldur || is_stur || is_rtype || is_cb || is_b || is_bl || is_br;
        dec_alu_src    = is_ldur || is_stur;
        dec_mem_read   = is_ldur;
        dec_mem_write  = is_stur;
        dec_mem_to_reg = is_ldur;
        dec_reg_write  = is_ldur || is_rtype || is_bl;
        dec_link       = is_bl;
        dec_alu_op     = 2'b00;
        if (is_rtype)
            dec_alu_op = 2'b10;
        else if (is_cb)
            dec_alu_op = 2'b01;
    end

    // --------------------------------------------------------- register file
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rd_data1, rd_data2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_reg_write && (wb_rd != XZR)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rd_data1 = regs[rs1];
        rd_data2 = regs[rs2];
`ifdef ID_BYPASS_EN
        if (wb_reg_write && (wb_rd == rs1))
            rd_data1 = wb_data;
        if (wb_reg_write && (wb_rd == rs2))
            rd_data2 = wb_data;
`endif
        if (rs1 == XZR)
            rd_data1 = '0;
        if (rs2 == XZR)
            rd_data2 = '0;
    end

    // ------------------------------------------------------------ hazard unit
    logic                  use1, use2, br_use;
    logic [REG_ADDR_W-1:0] br_src;
    logic                  load_use, branch_dep, wb_dep, hazard;

    always_comb begin
        // Sources that EX consumes (non-branch instructions only).
        use1   = is_ldur || is_stur || is_rtype;
        use2   = is_stur || is_rtype;
        // Branch operand is needed here in ID, so no forwarding can help it.
        br_use = is_cb || is_br;
        br_src = is_br ? rs1 : rs2;

        load_use = ex.ex_valid && ex.ex_mem_read &&
                   ((use1 && src_hit(rs1, ex.ex_rd)) || (use2 && src_hit(rs2, ex.ex_rd)));

        branch_dep = br_use &&
                     ((ex.ex_reg_write && src_hit(br_src, ex.ex_rd)) ||
                      (mem_reg_write   && src_hit(br_src, mem_rd)));

`ifdef ID_BYPASS_EN
        wb_dep = 1'b0;
`else
        // No write-through, so a value still in WB is invisible to ID.
        wb_dep = wb_reg_write &&
                 ((use1   && src_hit(rs1, wb_rd)) ||
                  (use2   && src_hit(rs2, wb_rd)) ||
                  (br_use && src_hit(br_src, wb_rd)));
`endif

        hazard = if_valid && (load_use || branch_dep || wb_dep);
    end

    // --------------------------------------------------------------- branches
    logic              br_eval, take;
    logic [DATA_W-1:0] pc_rel_target;

    always_comb begin
        pc_rel_target = if_pc + (imm << 2);
        stall         = reset && hazard;
        // A stalled instruction must not redirect, so stall and flush are exclusive.
        br_eval       = reset && if_valid && !hazard;
        take          = br_eval && (is_b || is_bl || is_br ||
                                    (is_cbz  && (rd_data2 == '0)) ||
                                    (is_cbnz && (rd_data2 != '0)));
        branch_taken  = take;
        flush         = take;
        branch_target = '0;
        if (take)
            branch_target = is_br ? rd_data1 : pc_rel_target;
    end

    // ------------------------------------------------------- ID/EX register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex.ex_valid      <= 1'b0;
            ex.ex_alu_src    <= 1'b0;
            ex.ex_mem_read   <= 1'b0;
            ex.ex_mem_write  <= 1'b0;
            ex.ex_mem_to_reg <= 1'b0;
            ex.ex_reg_write  <= 1'b0;
            ex.ex_link       <= 1'b0;
            ex.ex_alu_op     <= 2'b00;
            ex.ex_rn         <= '0;
            ex.ex_rm         <= '0;
            ex.ex_rd         <= '0;
            ex.ex_read_data1 <= '0;
            ex.ex_read_data2 <= '0;
            ex.ex_imm        <= '0;
            ex.ex_pc         <= '0;
        end else begin
            // Data fields always follow decode; only the controls form the bubble.
            ex.ex_rn         <= rs1;
            ex.ex_rm         <= rs2;
            ex.ex_rd         <= rd_idx;
            ex.ex_read_data1 <= rd_data1;
            ex.ex_read_data2 <= rd_data2;
            // BL carries its return address to EX in the immediate slot.
            ex.ex_imm        <= is_bl ? (if_pc + DATA_W'(4)) : imm;
            ex.ex_pc         <= if_pc;
            if (hazard || !if_valid) begin
                ex.ex_valid      <= 1'b0;
                ex.ex_alu_src    <= 1'b0;
                ex.ex_mem_read   <= 1'b0;
                ex.ex_mem_write  <= 1'b0;
                ex.ex_mem_to_reg <= 1'b0;
                ex.ex_reg_write  <= 1'b0;
                ex.ex_link       <= 1'b0;
                ex.ex_alu_op     <= 2'b00;
            end else begin
                ex.ex_valid      <= dec_valid;
                ex.ex_alu_src    <= dec_alu_src;
                ex.ex_mem_read   <= dec_mem_read;
                ex.ex_mem_write  <= dec_mem_write;
                ex.ex_mem_to_reg <= dec_mem_to_reg;
                ex.ex_reg_write  <= dec_reg_write;
                ex.ex_link       <= dec_link;
                ex.ex_alu_op     <= dec_alu_op;
            end
        end
    end

    // ---------------------------------------------------------- stall counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed bench for id_stage_hazard with a 4-bit stall counter.
// Latency: registered outputs sampled 1 time unit after the rising edge.
// Backpressure: stall is sampled combinationally mid-cycle before each edge.
module tb_id_stage_hazard;
    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 4;
`ifdef ID_BYPASS_EN
    localparam int CBZ_STALLS = 2;
    localparam logic [63:0] SAME_CYCLE_X9 = 64'hAB;
`else
    localparam int CBZ_STALLS = 3;
    localparam logic [63:0] SAME_CYCLE_X9 = 64'h99;
`endif

    localparam logic [31:0] I_ADD_X3_X31_X5 = 32'h8B0503E3;
    localparam logic [31:0] I_ADD_X3_X5_X31 = 32'h8B1F00A3;
    localparam logic [31:0] I_LDUR_X2_X1_8  = 32'hF8408022;
    localparam logic [31:0] I_ADD_X3_X2_X4  = 32'h8B040043;
    localparam logic [31:0] I_B_MINUS2      = 32'h17FFFFFE;
    localparam logic [31:0] I_B_PLUS4       = 32'h14000004;
    localparam logic [31:0] I_BL_4          = 32'h94000004;
    localparam logic [31:0] I_BR_X10        = 32'hD6000140;
    localparam logic [31:0] I_STUR_X9_X8_M1 = 32'hF81FF109;
    localparam logic [31:0] I_LDUR_X0_X1_90 = 32'hF8490020;
    localparam logic [31:0] I_ADD_X7_X5_X6  = 32'h8B0600A7;
    localparam logic [31:0] I_CBZ_X7_3      = 32'hB4000067;

    logic                  clock;
    logic                  reset;
    logic                  if_valid;
    logic [31:0]           if_instr;
    logic [DATA_W-1:0]     if_pc;
    logic                  mem_reg_write;
    logic                  mem_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  stall;
    logic                  flush;
    logic                  branch_taken;
    logic [DATA_W-1:0]     branch_target;
    logic [CNT_W-1:0]      stall_count;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    id_stage_hazard_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) ex_bus ();

    id_stage_hazard #(
        .DATA_W(DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read),
        .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .stall(stall),
        .flush(flush),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .stall_count(stall_count),
        .ex(ex_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wb_write(input logic [REG_ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        wb_reg_write = 1'b1;
        wb_rd        = rd;
        wb_data      = d;
        tick();
        wb_reg_write = 1'b0;
    endtask

    initial begin
        reset = 1'b0; if_valid = 1'b1; if_instr = I_B_PLUS4; if_pc = 64'h40;
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        #1;
        // Reset state, with a taken-looking branch presented.
        chk("rst_branch_taken", 64'(branch_taken), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_target", branch_target, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ex_valid", 64'(ex_bus.ex_valid), 64'd0);
        chk("rst_stall_count", 64'(stall_count), 64'd0);
        tick(); tick();
        reset = 1'b1; if_valid = 1'b0;

        wb_write(5'd1, 64'h1000);
        wb_write(5'd5, 64'h55);
        wb_write(5'd7, 64'h77);
        wb_write(5'd9, 64'h99);
        wb_write(5'd10, 64'h2000);
        wb_write(5'd31, 64'hFFFF);

        // XZR reads as zero even after a write to it.
        if_valid = 1'b1; if_instr = I_ADD_X3_X31_X5; if_pc = 64'h80;
        #1 chk("add_no_stall", 64'(stall), 64'd0);
        tick();
        chk("add_valid", 64'(ex_bus.ex_valid), 64'd1);
        chk("xzr_read", ex_bus.ex_read_data1, 64'd0);
        chk("x5_read", ex_bus.ex_read_data2, 64'h55);
        chk("add_alu_op", 64'(ex_bus.ex_alu_op), 64'd2);
        chk("add_rn", 64'(ex_bus.ex_rn), 64'd31);

        // Load-use: LDUR X2 then ADD X3,X2,X4.
        if_instr = I_LDUR_X2_X1_8; if_pc = 64'h84;
        #1 chk("ldur_no_stall", 64'(stall), 64'd0);
        tick();
        chk("ldur_mem_read", 64'(ex_bus.ex_mem_read), 64'd1);
        chk("ldur_imm", ex_bus.ex_imm, 64'd8);
        chk("ldur_rd", 64'(ex_bus.ex_rd), 64'd2);
        chk("ldur_base", ex_bus.ex_read_data1, 64'h1000);
        if_instr = I_ADD_X3_X2_X4; if_pc = 64'h88;
        mem_reg_write = 1'b1; mem_mem_read = 1'b0; mem_rd = 5'd3;
        #1;
        chk("lu_stall", 64'(stall), 64'd1);
        chk("lu_no_flush", 64'(flush), 64'd0);
        tick();
        chk("lu_bubble", 64'(ex_bus.ex_valid), 64'd0);
        chk("lu_count", 64'(stall_count), 64'd1);
        mem_rd = 5'd2; mem_mem_read = 1'b1;
        #1 chk("lu_released", 64'(stall), 64'd0);
        tick();
        chk("lu_issue_valid", 64'(ex_bus.ex_valid), 64'd1);
        chk("lu_issue_rn", 64'(ex_bus.ex_rn), 64'd2);
        chk("lu_issue_rm", 64'(ex_bus.ex_rm), 64'd4);
        chk("lu_count_hold", 64'(stall_count), 64'd1);
        mem_reg_write = 1'b0; mem_mem_read = 1'b0;

        // Backward B.
        if_instr = I_B_MINUS2; if_pc = 64'h200;
        #1;
        chk("b_taken", 64'(branch_taken), 64'd1);
        chk("b_flush", 64'(flush), 64'd1);
        chk("b_target", branch_target, 64'h1F8);
        tick();
        chk("b_no_write", 64'(ex_bus.ex_reg_write), 64'd0);

        // BL at 0x100, imm26 = 4.
        if_instr = I_BL_4; if_pc = 64'h100;
        #1;
        chk("bl_taken", 64'(branch_taken), 64'd1);
        chk("bl_target", branch_target, 64'h110);
        tick();
        chk("bl_rd", 64'(ex_bus.ex_rd), 64'd30);
        chk("bl_imm", ex_bus.ex_imm, 64'h104);
        chk("bl_reg_write", 64'(ex_bus.ex_reg_write), 64'd1);
        chk("bl_link", 64'(ex_bus.ex_link), 64'd1);

        // BR X10.
        if_instr = I_BR_X10; if_pc = 64'h104;
        #1;
        chk("br_taken", 64'(branch_taken), 64'd1);
        chk("br_target", branch_target, 64'h2000);
        chk("br_no_stall", 64'(stall), 64'd0);
        tick();

        // STUR with negative offset; Rt read on port 2.
        if_instr = I_STUR_X9_X8_M1; if_pc = 64'h108;
        #1 chk("stur_not_taken", 64'(branch_taken), 64'd0);
        tick();
        chk("stur_mem_write", 64'(ex_bus.ex_mem_write), 64'd1);
        chk("stur_imm", ex_bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("stur_rm", 64'(ex_bus.ex_rm), 64'd9);
        chk("stur_rt_data", ex_bus.ex_read_data2, 64'h99);

        // Same-cycle WB write and read of X9 (via port 2 of an LDUR).
        wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 64'hAB;
        if_instr = I_LDUR_X0_X1_90; if_pc = 64'h10C;
        #1 chk("wt_no_stall", 64'(stall), 64'd0);
        tick();
        chk("wt_same_cycle", ex_bus.ex_read_data2, SAME_CYCLE_X9);
        wb_reg_write = 1'b0;
        tick();
        chk("wt_after", ex_bus.ex_read_data2, 64'hAB);

        // ADD X7 then CBZ X7 where X7 becomes 0.
        if_instr = I_ADD_X7_X5_X6; if_pc = 64'h300;
        #1 chk("add7_no_stall", 64'(stall), 64'd0);
        tick();
        if_instr = I_CBZ_X7_3; if_pc = 64'h304;
        #1;
        chk("cbz_stall_ex", 64'(stall), 64'd1);
        chk("cbz_ex_no_flush", 64'(flush), 64'd0);
        chk("cbz_ex_not_taken", 64'(branch_taken), 64'd0);
        tick();
        mem_reg_write = 1'b1; mem_rd = 5'd7;
        #1;
        chk("cbz_stall_mem", 64'(stall), 64'd1);
        chk("cbz_mem_no_flush", 64'(flush), 64'd0);
        tick();
        mem_reg_write = 1'b0;
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 64'd0;
`ifndef ID_BYPASS_EN
        #1;
        chk("cbz_stall_wb", 64'(stall), 64'd1);
        chk("cbz_wb_not_taken", 64'(branch_taken), 64'd0);
        tick();
        wb_reg_write = 1'b0;
`endif
        #1;
        chk("cbz_released", 64'(stall), 64'd0);
        chk("cbz_taken", 64'(branch_taken), 64'd1);
        chk("cbz_flush", 64'(flush), 64'd1);
        chk("cbz_target", branch_target, 64'h310);
        tick();
        wb_reg_write = 1'b0;
        chk("cbz_count", 64'(stall_count), 64'(1 + CBZ_STALLS));

        // Asynchronous reset mid-run.
        if_instr = I_ADD_X3_X31_X5; if_pc = 64'h400;
        tick();
        chk("pre_rst_reg_write", 64'(ex_bus.ex_reg_write), 64'd1);
        reset = 1'b0; if_instr = I_B_PLUS4;
        #1;
        chk("mid_rst_reg_write", 64'(ex_bus.ex_reg_write), 64'd0);
        chk("mid_rst_valid", 64'(ex_bus.ex_valid), 64'd0);
        chk("mid_rst_rd", 64'(ex_bus.ex_rd), 64'd0);
        chk("mid_rst_pc", ex_bus.ex_pc, 64'd0);
        chk("mid_rst_count", 64'(stall_count), 64'd0);
        chk("mid_rst_taken", 64'(branch_taken), 64'd0);
        tick();
        reset = 1'b1; if_instr = I_ADD_X3_X5_X31; if_pc = 64'h408;
        tick();
        chk("post_rst_valid", 64'(ex_bus.ex_valid), 64'd1);
        chk("post_rst_x5", ex_bus.ex_read_data1, 64'd0);

        // Saturation: hold a CB operand dependency on MEM.
        if_instr = I_CBZ_X7_3; if_pc = 64'h40C;
        mem_reg_write = 1'b1; mem_rd = 5'd7;
        #1 chk("sat_stall", 64'(stall), 64'd1);
        for (int i = 0; i < 14; i++) tick();
        chk("sat_count_14", 64'(stall_count), 64'd14);
        tick();
        chk("sat_count_15", 64'(stall_count), 64'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", 64'(stall_count), 64'd15);
        chk("sat_still_stall", 64'(stall), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
